// File: rtl/corcpu_pkg.sv
// Shared core types: tag width, data width, register count and the
// functional-unit list that sizes the result writeback path.
package corcpu_pkg;

   localparam int XLEN     = 32;
   localparam int NUM_REGS = 32;
   localparam int TAG_W    = 3;

   // Tag value 0 means "no producer"
   typedef logic [TAG_W-1:0] tag_t;

   typedef enum logic [1:0] {
      FU_ALU,
      FU_BRU,
      FU_MUL,
      FU_LSU
   } e_functional_unit;

   // Member count of e_functional_unit: one CDB source per unit
   localparam int FU_COUNT = int'(FU_LSU) + 1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request found at or
// above ptr, wrapping from N-1 back to 0.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int PTR_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant
);

   // Scan farthest-first so the nearest requester overwrites earlier hits
   always_comb begin
      grant = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % N]) begin
            grant = '0;
            grant[(int'(ptr) + k) % N] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cdb_writeback.sv
// Common data bus writeback: one holding entry per FU, round-robin drain
// onto a registered CDB. Optional counters under CDB_STATS_EN.
module cdb_writeback
   import corcpu_pkg::*;
#(
   parameter int NUM_FU   = FU_COUNT,
   parameter int XLEN     = corcpu_pkg::XLEN,
   parameter int TAG_W    = $bits(tag_t),
   parameter int NUM_REGS = corcpu_pkg::NUM_REGS
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_FU-1:0]              fu_valid,
   output logic [NUM_FU-1:0]              fu_ready,
   input  logic [NUM_FU-1:0][TAG_W-1:0]   fu_tag,
   input  logic [NUM_FU-1:0][XLEN-1:0]    fu_value,
   output logic                           cdb_valid,
   output logic [TAG_W-1:0]               cdb_tag,
   output logic [XLEN-1:0]                cdb_value,
   input  logic [NUM_REGS-1:0][TAG_W-1:0] rf_qi,
   input  logic                           issue_we,
   input  logic [4:0]                     issue_rd,
`ifdef CDB_STATS_EN
   output logic [31:0]                    stat_bcast,
   output logic [31:0]                    stat_stall,
`endif
   output logic [NUM_REGS-1:0]            rf_wb_mask
);

   localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

   logic [NUM_FU-1:0]            held_q, held_d;
   logic [NUM_FU-1:0][TAG_W-1:0] tag_q, tag_d;
   logic [NUM_FU-1:0][XLEN-1:0]  val_q, val_d;
   logic [PTR_W-1:0]             rr_ptr_q, rr_ptr_d;
   logic                         cdb_valid_q, cdb_valid_d;
   logic [TAG_W-1:0]             cdb_tag_q, cdb_tag_d;
   logic [XLEN-1:0]              cdb_value_q, cdb_value_d;
   logic [NUM_FU-1:0]            grant;
   logic [NUM_FU-1:0]            accept;
   logic [PTR_W-1:0]             gnt_idx;

   rr_arbiter #(
      .N     (NUM_FU),
      .PTR_W (PTR_W)
   ) u_arb (
      .req   (held_q),
      .ptr   (rr_ptr_q),
      .grant (grant)
   );

   // An entry is free, or frees up on this edge because it is draining
   assign fu_ready  = ~held_q | grant;
   assign accept    = fu_valid & fu_ready;
   assign cdb_valid = cdb_valid_q;
   assign cdb_tag   = cdb_tag_q;
   assign cdb_value = cdb_value_q;

   // Binary index of the granted entry
   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         if (grant[i]) gnt_idx = PTR_W'(i);
      end
   end

   // Holding entries: refill on accept (tag 0 leaves it empty), else drain
   always_comb begin
      held_d = held_q;
      tag_d  = tag_q;
      val_d  = val_q;
      for (int i = 0; i < NUM_FU; i++) begin
         if (accept[i]) begin
            held_d[i] = |fu_tag[i];
            tag_d[i]  = fu_tag[i];
            val_d[i]  = fu_value[i];
         end else if (grant[i]) begin
            held_d[i] = 1'b0;
         end
      end
   end

   // Broadcast register and round-robin pointer advance
   always_comb begin
      cdb_valid_d = |held_q;
      cdb_tag_d   = cdb_tag_q;
      cdb_value_d = cdb_value_q;
      rr_ptr_d    = rr_ptr_q;
      for (int i = 0; i < NUM_FU; i++) begin
         if (grant[i]) begin
            cdb_tag_d   = tag_q[i];
            cdb_value_d = val_q[i];
         end
      end
      if (|held_q) begin
         rr_ptr_d = (gnt_idx == PTR_W'(NUM_FU - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   // Register-file writeback mask; a same-cycle rename of rd wins
   always_comb begin
      rf_wb_mask = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         rf_wb_mask[r] = cdb_valid_q
                       && (rf_qi[r] == cdb_tag_q)
                       && !(issue_we && (issue_rd == 5'(r)));
      end
   end

   // Datapath and control state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         held_q      <= '0;
         tag_q       <= '0;
         val_q       <= '0;
         rr_ptr_q    <= '0;
         cdb_valid_q <= 1'b0;
         cdb_tag_q   <= '0;
         cdb_value_q <= '0;
      end else begin
         held_q      <= held_d;
         tag_q       <= tag_d;
         val_q       <= val_d;
         rr_ptr_q    <= rr_ptr_d;
         cdb_valid_q <= cdb_valid_d;
         cdb_tag_q   <= cdb_tag_d;
         cdb_value_q <= cdb_value_d;
      end
   end

`ifdef CDB_STATS_EN
   logic [31:0] stat_bcast_q, stat_bcast_d;
   logic [31:0] stat_stall_q, stat_stall_d;

   assign stat_bcast = stat_bcast_q;
   assign stat_stall = stat_stall_q;

   // Count broadcasts and cycles where some FU is back-pressured
   always_comb begin
      stat_bcast_d = stat_bcast_q + (cdb_valid_d ? 32'd1 : 32'd0);
      stat_stall_d = stat_stall_q
                   + ((|(fu_valid & ~fu_ready)) ? 32'd1 : 32'd0);
   end

   // Statistics counters, wrapping naturally
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_bcast_q <= '0;
         stat_stall_q <= '0;
      end else begin
         stat_bcast_q <= stat_bcast_d;
         stat_stall_q <= stat_stall_d;
      end
   end
`endif

endmodule

// File: tb/tb_cdb_writeback.sv
// Bench for cdb_writeback: directed scenarios then random traffic,
// all checked against a queue-free slot model of the writeback rules.
`timescale 1ns/1ps
module tb_cdb_writeback;
   import corcpu_pkg::*;

   localparam int NFU = 4;
   localparam int NR  = 32;
   localparam int TW  = 3;
   localparam int XW  = 32;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NFU-1:0]        fu_valid;
   logic [NFU-1:0]        fu_ready;
   logic [NFU-1:0][TW-1:0] fu_tag;
   logic [NFU-1:0][XW-1:0] fu_value;
   logic                  cdb_valid;
   logic [TW-1:0]         cdb_tag;
   logic [XW-1:0]         cdb_value;
   logic [NR-1:0][TW-1:0] rf_qi;
   logic                  issue_we;
   logic [4:0]            issue_rd;
   logic [NR-1:0]         rf_wb_mask;
`ifdef CDB_STATS_EN
   logic [31:0]           stat_bcast;
   logic [31:0]           stat_stall;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   cdb_writeback dut (
      .clk        (clk),
      .rst        (rst),
      .fu_valid   (fu_valid),
      .fu_ready   (fu_ready),
      .fu_tag     (fu_tag),
      .fu_value   (fu_value),
      .cdb_valid  (cdb_valid),
      .cdb_tag    (cdb_tag),
      .cdb_value  (cdb_value),
      .rf_qi      (rf_qi),
      .issue_we   (issue_we),
      .issue_rd   (issue_rd),
`ifdef CDB_STATS_EN
      .stat_bcast (stat_bcast),
      .stat_stall (stat_stall),
`endif
      .rf_wb_mask (rf_wb_mask)
   );

   // Reference model: slots, next-to-serve pointer, last broadcast
   bit [NFU-1:0]  m_held;
   logic [TW-1:0] m_tag [NFU];
   logic [XW-1:0] m_val [NFU];
   int            m_ptr;
   bit            m_cv;
   logic [TW-1:0] m_ct;
   logic [XW-1:0] m_cval;
   int unsigned   m_bc;
   int unsigned   m_st;

   task automatic m_reset();
      m_held = '0;
      for (int i = 0; i < NFU; i++) begin
         m_tag[i] = '0;
         m_val[i] = '0;
      end
      m_ptr  = 0;
      m_cv   = 0;
      m_ct   = '0;
      m_cval = '0;
      m_bc   = 0;
      m_st   = 0;
   endtask

   function automatic int m_grant();
      for (int k = 0; k < NFU; k++) begin
         if (m_held[(m_ptr + k) % NFU]) return (m_ptr + k) % NFU;
      end
      return -1;
   endfunction

   function automatic logic [NFU-1:0] m_ready();
      logic [NFU-1:0] r;
      int g;
      g = m_grant();
      for (int i = 0; i < NFU; i++) r[i] = !m_held[i] || (i == g);
      return r;
   endfunction

   function automatic logic [NR-1:0] m_mask();
      logic [NR-1:0] m;
      for (int r = 0; r < NR; r++) begin
         m[r] = m_cv && (rf_qi[r] == m_ct)
              && !(issue_we && (int'(issue_rd) == r));
      end
      return m;
   endfunction

   task automatic check(input string name,
                        input logic [63:0] obs,
                        input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // Compare outputs with model, advance model, cross one rising edge
   task automatic tick();
      logic [NFU-1:0] rdy;
      int g;
      if (rst) m_reset();
      #1;
      rdy = m_ready();
      check("fu_ready", 64'(fu_ready), 64'(rdy));
      check("rf_wb_mask", 64'(rf_wb_mask), 64'(m_mask()));
      check("cdb_valid", 64'(cdb_valid), 64'(m_cv));
      if (m_cv) begin
         check("cdb_tag", 64'(cdb_tag), 64'(m_ct));
         check("cdb_value", 64'(cdb_value), 64'(m_cval));
      end
`ifdef CDB_STATS_EN
      check("stat_bcast", 64'(stat_bcast), 64'(m_bc));
      check("stat_stall", 64'(stat_stall), 64'(m_st));
`endif
      if (!rst) begin
         g = m_grant();
         if ((fu_valid & ~rdy) != '0) m_st++;
         if (g >= 0) begin
            m_cv   = 1;
            m_ct   = m_tag[g];
            m_cval = m_val[g];
            m_ptr  = (g + 1) % NFU;
            m_bc++;
         end else begin
            m_cv = 0;
         end
         for (int i = 0; i < NFU; i++) begin
            if (fu_valid[i] && rdy[i]) begin
               m_held[i] = (fu_tag[i] != '0);
               m_tag[i]  = fu_tag[i];
               m_val[i]  = fu_value[i];
            end else if (i == g) begin
               m_held[i] = 0;
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst      = 1'b1;
      fu_valid = '0;
      fu_tag   = '0;
      fu_value = '0;
      rf_qi    = '0;
      issue_we = 1'b0;
      issue_rd = '0;
      m_reset();
      @(negedge clk);
      #1;
      check("rst_ready", 64'(fu_ready), 64'hf);
      check("rst_mask", 64'(rf_wb_mask), 64'h0);
      check("rst_cdb_valid", 64'(cdb_valid), 64'h0);
      tick();
      rst = 1'b0;
      tick();

      // Single FU1 result, tag 3 -> r5
      rf_qi[5]    = 3'd3;
      fu_valid    = 4'b0010;
      fu_tag[1]   = 3'd3;
      fu_value[1] = 32'hDEADBEEF;
      tick();
      fu_valid = '0;
      tick();
      check("single_valid", 64'(cdb_valid), 64'h1);
      check("single_tag", 64'(cdb_tag), 64'h3);
      check("single_value", 64'(cdb_value), 64'hDEADBEEF);
      check("single_mask", 64'(rf_wb_mask), 64'h20);
      rf_qi = '0;
      tick();
      tick();

      // Reset with three entries held
      fu_valid = 4'b0111;
      for (int i = 0; i < 3; i++) begin
         fu_tag[i]   = TW'(i + 5);
         fu_value[i] = 32'h1000 + 32'(i);
      end
      tick();
      fu_valid = '0;
      rst      = 1'b1;
      #1;
      check("midrst_valid", 64'(cdb_valid), 64'h0);
      check("midrst_ready", 64'(fu_ready), 64'hf);
      check("midrst_mask", 64'(rf_wb_mask), 64'h0);
      tick();
      rst = 1'b0;
      tick();
      check("postrst_nobcast1", 64'(cdb_valid), 64'h0);
      tick();
      check("postrst_nobcast2", 64'(cdb_valid), 64'h0);

      // All four FUs at once from pointer 0
      fu_valid = 4'b1111;
      for (int i = 0; i < NFU; i++) begin
         fu_tag[i]   = TW'(i + 1);
         fu_value[i] = 32'h100 + 32'(i);
      end
      tick();
      fu_valid = '0;
      #1;
      check("rr_ready0", 64'(fu_ready), 64'b0001);
      for (int k = 1; k <= NFU; k++) begin
         tick();
         check($sformatf("rr_valid%0d", k), 64'(cdb_valid), 64'h1);
         check($sformatf("rr_tag%0d", k), 64'(cdb_tag), 64'(k));
         if (k == 1) check("rr_ready1", 64'(fu_ready), 64'b0011);
      end
      tick();
      check("rr_idle", 64'(cdb_valid), 64'h0);

      // Issuer rename of r7 suppresses its writeback
      rf_qi[7]    = 3'd2;
      rf_qi[9]    = 3'd2;
      fu_valid    = 4'b0001;
      fu_tag[0]   = 3'd2;
      fu_value[0] = 32'h77;
      tick();
      fu_valid = '0;
      tick();
      issue_we = 1'b1;
      issue_rd = 5'd7;
      #1;
      check("rename_mask", 64'(rf_wb_mask), 64'h200);
      issue_we = 1'b0;
      #1;
      check("norename_mask", 64'(rf_wb_mask), 64'h280);
      tick();
      rf_qi = '0;

      // FU2 streaming back-to-back
      for (int k = 0; k < 8; k++) begin
         fu_valid    = 4'b0100;
         fu_tag[2]   = TW'((k % 7) + 1);
         fu_value[2] = $urandom;
         #1;
         check("stream_ready", 64'(fu_ready[2]), 64'h1);
         tick();
         if (k >= 1) begin
            check("stream_valid", 64'(cdb_valid), 64'h1);
            check("stream_tag", 64'(cdb_tag), 64'(((k - 1) % 7) + 1));
         end
      end
      fu_valid = '0;
      tick();
      tick();

      // Tag 0 is accepted and discarded
      fu_valid  = 4'b1000;
      fu_tag[3] = '0;
      #1;
      check("tag0_ready", 64'(fu_ready[3]), 64'h1);
      tick();
      fu_valid = '0;
      tick();
      check("tag0_nobcast1", 64'(cdb_valid), 64'h0);
      tick();
      check("tag0_nobcast2", 64'(cdb_valid), 64'h0);

      // Random traffic with occasional reset
      for (int c = 0; c < 400; c++) begin
         fu_valid = NFU'($urandom);
         for (int i = 0; i < NFU; i++) begin
            fu_tag[i]   = TW'($urandom_range(0, 7));
            fu_value[i] = $urandom;
         end
         for (int r = 0; r < NR; r++) rf_qi[r] = TW'($urandom);
         issue_we = 1'($urandom_range(0, 1));
         issue_rd = 5'($urandom);
         rst      = ($urandom_range(0, 39) == 0);
         tick();
      end
      rst      = 1'b0;
      fu_valid = '0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cdb_writeback.md
CDB_WRITEBACK -- requirements
Module: cdb_writeback

Interface
REQ-001 SHALL have parameter NUM_FU, default 4; number of functional-unit result ports.
REQ-002 SHALL have parameter XLEN, default 32; result value width.
REQ-003 SHALL have parameter TAG_W, default 3; reservation-station tag width; tag 0 = "no producer".
REQ-004 SHALL have parameter NUM_REGS, default 32; architectural register count.
REQ-005 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port fu_valid  in  NUM_FU  per-FU result offered.
REQ-008 SHALL have port fu_ready  out  NUM_FU  per-FU result accepted this cycle when valid&ready.
REQ-009 SHALL have port fu_tag  in  NUM_FU x TAG_W  producing reservation-station tag.
REQ-010 SHALL have port fu_value  in  NUM_FU x XLEN  result value.
REQ-011 SHALL have port cdb_valid  out  1  broadcast active.
REQ-012 SHALL have port cdb_tag  out  TAG_W  broadcast tag.
REQ-013 SHALL have port cdb_value  out  XLEN  broadcast value.
REQ-014 SHALL have port rf_qi  in  NUM_REGS x TAG_W  current register-file Qi fields.
REQ-015 SHALL have port issue_we  in  1  issuer renaming a destination this cycle.
REQ-016 SHALL have port issue_rd  in  5  destination register being renamed.
REQ-017 SHALL have port rf_wb_mask  out  NUM_REGS  per-register: write cdb_value, clear Qi.

Function
REQ-018 SHALL hold one result per FU in a holding entry (held bit, tag, value).
REQ-019 SHALL drive fu_ready[i] = ~held[i] | grant[i] (free or being drained this edge); one result/cycle/FU when uncontested.
REQ-020 SHALL capture fu_tag/fu_value into entry i on the edge where fu_valid[i]&fu_ready[i].
REQ-021 SHALL accept-and-discard a result with tag 0: fu_ready follows REQ-019, entry stays empty, nothing broadcast.
REQ-022 SHALL grant at most one held entry per cycle, round-robin: search from rr_ptr upward, wrapping at NUM_FU-1 to 0.
REQ-023 SHALL set rr_ptr to (granted index + 1) mod NUM_FU after a grant; unchanged when nothing held.
REQ-024 SHALL register the granted entry into cdb_valid/tag/value on the grant edge and clear its held bit unless refilled that same edge.
REQ-025 SHALL deassert cdb_valid on an edge with no held entry; latency FU accept -> cdb_valid = 2 edges minimum.
REQ-026 SHALL drive rf_wb_mask[r] combinationally = cdb_valid & (rf_qi[r]==cdb_tag) & ~(issue_we & issue_rd==r); issuer rename wins.
REQ-027 SHALL allow multiple mask bits set (one tag renaming several registers never occurs, but no one-hot assumption is made).

Reset
REQ-028 SHALL on rst clear all held bits, cdb_valid, cdb_tag, cdb_value, rr_ptr to 0; fu_ready all-ones, rf_wb_mask all-zero during reset.
REQ-029 SHALL drop in-flight held results on mid-operation reset; no broadcast on the first edge after release.

Configuration
REQ-030 SHALL, with CDB_STATS_EN defined, add outputs stat_bcast (32-bit, +1 per edge registering cdb_valid=1) and stat_stall (32-bit, +1 per cycle with any fu_valid&~fu_ready), both reset to 0, wrapping at 2^32.
REQ-031 SHALL, without CDB_STATS_EN, omit those ports and counters; all other behaviour identical.

Structure
REQ-032 SHALL take tag_t, XLEN, NUM_REGS and e_functional_unit from the shared corcpu_pkg; NUM_FU = e_functional_unit member count at instantiation.
REQ-033 SHALL implement arbitration in one sub-module rr_arbiter (request vector, rr_ptr in; one-hot grant out).

Verification
REQ-034 Single FU1 result tag 3 value 0xDEADBEEF, rf_qi[5]=3 -> after 2 edges cdb_valid=1, tag 3, rf_wb_mask=0x20.
REQ-035 FU0..FU3 valid same cycle (tags 1..4), rr_ptr=0 -> broadcasts tags 1,2,3,4 on 4 consecutive cycles; fu_ready low on waiting FUs.
REQ-036 Broadcast tag 2 for r7 while issue_we=1, issue_rd=7 -> rf_wb_mask[7]=0; other matching registers still set.
REQ-037 FU2 streaming back-to-back, others idle -> fu_ready[2] stays 1, cdb_valid high every cycle after second edge.
REQ-038 Assert rst with 3 entries held -> cdb_valid=0, no broadcast after release, rr_ptr=0; tag-0 result -> never broadcast.
